// File: rtl/serial_link_pkg.sv
// Shared serial-link definitions: state encoding, default geometry, line levels.
// Used by both the frame transmitter and the matching latch-based receiver.
package serial_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DIV   = 4;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity of a word of up to 16 bits (zero-extend narrower words).
    function automatic logic even_parity16(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word-in / serial-out link bundle between a word source and serial_frame_tx.
// master = word source, slave = transmitter.
interface serial_frame_tx_if
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             Load;
    logic [WIDTH-1:0] Data;
    logic             Ready;
    logic             SerOut;
    logic             Gate;

    modport master (
        output Load,
        output Data,
        input  Ready,
        input  SerOut,
        input  Gate
    );

    modport slave (
        input  Load,
        input  Data,
        output Ready,
        output SerOut,
        output Gate
    );
endinterface

// File: rtl/serial_tx_baud.sv
// Bit-period divider: counts 0..DIV-1 while a frame runs, flags bit end and mid-bit.
// Latency: counter is 0 in the first cycle after clear; no backpressure.
// Held at zero while idle; wraps DIV-1 -> 0.
module serial_tx_baud #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic run,
    output logic bit_end,
    output logic bit_mid,
    output logic mid_next
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(DIV / 2);
    localparam logic [CW-1:0] CNT_PRE  = CW'(DIV / 2 - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn || clear || !run) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end  = (cnt == CNT_LAST);
    assign bit_mid  = (cnt == CNT_MID);
    // One cycle ahead of bit_mid, so a registered strobe lands on the centre.
    assign mid_next = (cnt == CNT_PRE);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter (start, LSB-first data, optional parity, stop) with mid-bit Gate.
// Latency: SerOut goes to start level the cycle after Load is accepted; frame is (WIDTH+2[+1])*DIV cycles.
// Backpressure: Load is honoured only while Ready=1; parity bit enabled by SERIAL_TX_PARITY_EN.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DIV   = DEFAULT_DIV
) (
    input  logic             Clk,
    input  logic             Resetn,
    serial_frame_tx_if.slave link
);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [BW-1:0]    bit_cnt;
    logic             ser_out;
    logic             ready;
    logic             gate;
`ifdef SERIAL_TX_PARITY_EN
    logic             parity_bit;
`endif

    logic accept;
    logic in_bit;
    logic bit_end;
    logic bit_mid;
    logic mid_next;

    assign accept = (state == ST_IDLE) && link.Load;
    assign in_bit = (state == ST_DATA) || (state == ST_PARITY);

    serial_tx_baud #(
        .DIV (DIV)
    ) u_baud (
        .clk      (Clk),
        .resetn   (Resetn),
        .clear    (accept),
        .run      (state != ST_IDLE),
        .bit_end  (bit_end),
        .bit_mid  (bit_mid),
        .mid_next (mid_next)
    );

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            ser_out    <= LINE_IDLE;
            ready      <= 1'b1;
            gate       <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            gate <= in_bit && mid_next;
            case (state)
                ST_IDLE: begin
                    if (link.Load) begin
                        shift_reg  <= link.Data;
                        bit_cnt    <= '0;
                        ser_out    <= START_LEVEL;
                        ready      <= 1'b0;
                        state      <= ST_START;
`ifdef SERIAL_TX_PARITY_EN
                        parity_bit <= even_parity16(16'(link.Data));
`endif
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        ser_out <= shift_reg[0];
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
                            ser_out <= parity_bit;
                            state   <= ST_PARITY;
`else
                            ser_out <= STOP_LEVEL;
                            state   <= ST_STOP;
`endif
                        end else begin
                            // Next bit is already sitting one place up in the register.
                            bit_cnt <= bit_cnt + BW'(1);
                            ser_out <= shift_reg[1];
                        end
                    end
                end
`ifdef SERIAL_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        ser_out <= STOP_LEVEL;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        ser_out <= LINE_IDLE;
                        ready   <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    ser_out <= LINE_IDLE;
                    ready   <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign link.Ready  = ready;
    assign link.SerOut = ser_out;
    assign link.Gate   = gate;

    // The capture strobe must coincide with the divider's centre count.
    gate_on_centre: assert property (@(posedge Clk) disable iff (!Resetn) gate |-> bit_mid);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx (WIDTH=8, DIV=4); honours SERIAL_TX_PARITY_EN.
module tb_serial_frame_tx;
    import serial_link_pkg::*;

    localparam int W   = 8;
    localparam int DIV = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int F = (W + 2 + PAR) * DIV;

    logic Clk = 1'b0;
    logic Resetn;
    int   tests  = 0;
    int   failed = 0;

    serial_frame_tx_if #(.WIDTH(W)) link ();

    serial_frame_tx #(
        .WIDTH (W),
        .DIV   (DIV)
    ) dut (
        .Clk    (Clk),
        .Resetn (Resetn),
        .link   (link)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] data;
        logic [7:0] data_after;
        logic       exp_par;
        bit         hold;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: per-cycle line/ready/gate derived from the frame layout alone.
    function automatic void model(input logic [7:0] d, input logic par,
                                  output logic [63:0] es, output logic [63:0] er,
                                  output logic [63:0] eg);
        es = '0;
        er = '0;
        eg = '0;
        for (int c = 0; c <= F; c++) begin
            int b;
            b = c / DIV;
            if (c == F) begin
                es[c] = 1'b1;
                er[c] = 1'b1;
            end else begin
                if (b == 0)                    es[c] = 1'b0;
                else if (b <= W)               es[c] = d[b-1];
                else if (PAR == 1 && b == W+1) es[c] = par;
                else                           es[c] = 1'b1;
                eg[c] = (b >= 1) && (b <= W + PAR) && ((c % DIV) == DIV / 2);
            end
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where Ready is back.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] d_after, input logic par,
                             input bit hold, input string tag,
                             output logic [63:0] ser_v, output logic [63:0] rdy_v,
                             output logic [63:0] gate_v);
        logic [63:0] es, er, eg;
        ser_v  = '0;
        rdy_v  = '0;
        gate_v = '0;
        link.Load = 1'b1;
        link.Data = d;
        for (int c = 0; c <= F; c++) begin
            @(negedge Clk);
            ser_v[c]  = link.SerOut;
            rdy_v[c]  = link.Ready;
            gate_v[c] = link.Gate;
            if (c == 0) link.Data = d_after;
            if (c < F) link.Load = hold || ($urandom_range(0, 1) == 1);
            else       link.Load = hold;
        end
        model(d, par, es, er, eg);
        chk({tag, " serout"}, ser_v, es);
        chk({tag, " ready"},  rdy_v, er);
        chk({tag, " gate"},   gate_v, eg);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [63:0] sv, rv, gv;
        logic [15:0] act_bits, exp_bits;
        int          a5_seq[W+2+PAR];
        int          first, last, n, low, bad;

        tbl[0] = '{data: 8'hA5, data_after: 8'hA5, exp_par: 1'b0, hold: 1'b0};
        tbl[1] = '{data: 8'h01, data_after: 8'h01, exp_par: 1'b1, hold: 1'b0};
        tbl[2] = '{data: 8'h3C, data_after: 8'hFF, exp_par: 1'b0, hold: 1'b0};
        tbl[3] = '{data: 8'h00, data_after: 8'h00, exp_par: 1'b0, hold: 1'b1};
        tbl[4] = '{data: 8'hFF, data_after: 8'hFF, exp_par: 1'b0, hold: 1'b1};
        tbl[5] = '{data: 8'h80, data_after: 8'h7F, exp_par: 1'b1, hold: 1'b0};

`ifdef SERIAL_TX_PARITY_EN
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
        a5_seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif

        // Reset held with Load asserted: line stays idle.
        Resetn    = 1'b0;
        link.Load = 1'b1;
        link.Data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("reset ready",  link.Ready,  1);
            chk("reset serout", link.SerOut, 1);
            chk("reset gate",   link.Gate,   0);
        end
        Resetn    = 1'b1;
        link.Load = 1'b0;
        @(negedge Clk);
        chk("idle serout", link.SerOut, 1);
        chk("idle ready",  link.Ready,  1);

        // Hand-checked A5 frame: bit centres, gate placement, busy length.
        run_frame(8'hA5, 8'hA5, 1'b0, 1'b0, "a5", sv, rv, gv);
        act_bits = '0;
        exp_bits = '0;
        for (int b = 0; b < W + 2 + PAR; b++) begin
            act_bits[b] = sv[DIV*b + DIV/2];
            exp_bits[b] = (a5_seq[b] != 0);
        end
        chk("a5 bit centres", act_bits, exp_bits);
        first = -1;
        last  = -1;
        n     = 0;
        low   = 0;
        for (int c = 0; c < 64; c++) begin
            if (gv[c]) begin
                if (first < 0) first = c;
                last = c;
                n++;
            end
            if (c <= F && !rv[c]) low++;
        end
        chk("a5 first gate", first, 6);
`ifdef SERIAL_TX_PARITY_EN
        chk("a5 gate count", n, 9);
        chk("a5 last gate", last, 38);
        chk("a5 busy cycles", low, 44);
`else
        chk("a5 gate count", n, 8);
        chk("a5 last gate", last, 34);
        chk("a5 busy cycles", low, 40);
`endif

        // Table: parity values, data change after accept, back-to-back hold.
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].data, tbl[i].data_after, tbl[i].exp_par, tbl[i].hold,
                      $sformatf("tbl%0d", i), sv, rv, gv);
`ifdef SERIAL_TX_PARITY_EN
            chk($sformatf("tbl%0d parity", i), sv[DIV*(W+1) + DIV/2], tbl[i].exp_par);
`endif
        end
        link.Load = 1'b0;
        @(negedge Clk);

        // Reset during data bit 3: frame abandoned, not resumed.
        link.Load = 1'b1;
        link.Data = 8'hA5;
        @(negedge Clk);
        link.Load = 1'b0;
        for (int c = 1; c <= 17; c++) @(negedge Clk);
        chk("midreset bit3", link.SerOut, 0);
        Resetn = 1'b0;
        @(negedge Clk);
        chk("midreset serout", link.SerOut, 1);
        chk("midreset ready",  link.Ready,  1);
        chk("midreset gate",   link.Gate,   0);
        Resetn = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (link.SerOut !== 1'b1 || link.Ready !== 1'b1 || link.Gate !== 1'b0) bad++;
        end
        chk("midreset no resume", bad, 0);
        run_frame(8'h5A, 8'h00, 1'b0, 1'b0, "after reset", sv, rv, gv);

        // Random frames with random busy-time Load noise.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d, da;
            bit         h;
            d  = 8'($urandom_range(0, 255));
            da = 8'($urandom_range(0, 255));
            h  = ($urandom_range(0, 3) == 0);
            run_frame(d, da, 1'($countones(d) % 2), h, $sformatf("rand%0d", i), sv, rv, gv);
        end
        link.Load = 1'b0;
        @(negedge Clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
